// File: rtl/alu8_resp.sv
// alu8_resp -- registered, handshaked responder for an 8-bit ALU.
//
// Requests (A, B, ALU_Sel) are accepted over a valid/ready interface into
// stage 1. They are evaluated and registered into stage 2, which drives the
// result interface (ALU_Out, carry, zero) under out_valid/out_ready. The
// block holds up to two requests in flight and keeps full throughput while
// out_ready stays high.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid, in_ready  request handshake
//   A, B, ALU_Sel       operands and operation select
//   out_valid,out_ready result handshake
//   ALU_Out             result
//   carry               add carry-out / subtract borrow, 0 for logic ops
//   zero                ALU_Out == 0
//   op_count            completed output handshakes (wrapping)
module alu8_resp #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALU_Sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             carry,
  output logic             zero,
  output logic [CNT_W-1:0] op_count
);

  // Returns {carry, result}. The extra top bit of the add/sub gives carry
  // for addition and the unsigned borrow for subtraction.
  function automatic logic [WIDTH:0] alu_calc(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [2:0]       sel);
    logic [WIDTH:0] r;
    case (sel)
      3'b000:  r = {1'b0, a} + {1'b0, b};
      3'b001:  r = {1'b0, a} - {1'b0, b};
      3'b010:  r = {1'b0, a & b};
      3'b011:  r = {1'b0, a | b};
      3'b100:  r = {1'b0, a ^ b};
      3'b101:  r = {1'b0, ~(a & b)};
      3'b110:  r = {1'b0, ~(a | b)};
      default: r = {1'b0, ~(a ^ b)};
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] a_p1;
  logic [WIDTH-1:0] b_p1;
  logic [2:0]       sel_p1;
  logic             vld_p1;
  logic [WIDTH:0]   res_p1;
  logic             load_p2;
  logic             out_fire;

  // Stage 1 can accept whenever it is empty or its content is about to move on.
  assign in_ready = !vld_p1 || !out_valid || out_ready;
  assign load_p2  = vld_p1 && (!out_valid || out_ready);
  assign out_fire = out_valid && out_ready;

  always_comb begin
    res_p1 = alu_calc(a_p1, b_p1, sel_p1);
  end

  // ---- stage 1: request capture ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (in_ready) begin
      // When in_ready is high any held request is moving to stage 2 this edge,
      // so the slot may be overwritten (or emptied when nothing is offered).
      vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      a_p1   <= A;
      b_p1   <= B;
      sel_p1 <= ALU_Sel;
    end
  end

  // ---- stage 2: result register and output handshake ----
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      ALU_Out   <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
    end else if (load_p2) begin
      out_valid <= 1'b1;
      ALU_Out   <= res_p1[WIDTH-1:0];
      carry     <= res_p1[WIDTH];
      zero      <= (res_p1[WIDTH-1:0] == '0);
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
    end else if (out_fire) begin
      op_count <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_alu8_resp.sv
// Directed, table-driven bench for alu8_resp (counter narrowed to 4 bits so
// the wrap case is reachable quickly).
module tb_alu8_resp;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       ALU_Sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALU_Out;
  logic             carry;
  logic             zero;
  logic [CNT_W-1:0] op_count;

  alu8_resp #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALU_Sel(ALU_Sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALU_Out(ALU_Out), .carry(carry), .zero(zero),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] sel;
    logic [7:0] res;
    logic       c;
    logic       z;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic set_req(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
    A = a; B = b; ALU_Sel = s; in_valid = 1'b1;
  endtask

  vec_t       tbl[13];
  logic [7:0] b2b[6];
  int         exp_cnt;

  initial begin
    tbl[0]  = '{8'h0F, 8'h01, 3'b000, 8'h10, 1'b0, 1'b0};
    tbl[1]  = '{8'hFF, 8'h01, 3'b000, 8'h00, 1'b1, 1'b1};
    tbl[2]  = '{8'h01, 8'h02, 3'b001, 8'hFF, 1'b1, 1'b0};
    tbl[3]  = '{8'h80, 8'h80, 3'b000, 8'h00, 1'b1, 1'b1};
    tbl[4]  = '{8'h05, 8'h05, 3'b001, 8'h00, 1'b0, 1'b1};
    tbl[5]  = '{8'h10, 8'h01, 3'b001, 8'h0F, 1'b0, 1'b0};
    tbl[6]  = '{8'hF0, 8'h0F, 3'b010, 8'h00, 1'b0, 1'b1};
    tbl[7]  = '{8'hA5, 8'h5A, 3'b011, 8'hFF, 1'b0, 1'b0};
    tbl[8]  = '{8'hFF, 8'hFF, 3'b100, 8'h00, 1'b0, 1'b1};
    tbl[9]  = '{8'hFF, 8'hFF, 3'b101, 8'h00, 1'b0, 1'b1};
    tbl[10] = '{8'h00, 8'h00, 3'b110, 8'hFF, 1'b0, 1'b0};
    tbl[11] = '{8'h3C, 8'h3C, 3'b111, 8'hFF, 1'b0, 1'b0};
    tbl[12] = '{8'hFF, 8'hFF, 3'b010, 8'hFF, 1'b0, 1'b0};
    b2b = '{8'h88, 8'hEE, 8'h66, 8'h77, 8'h11, 8'h99};

    A = '0; B = '0; ALU_Sel = '0;
    do_reset();

    // Reset state
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_alu_out", ALU_Out, 8'h00);
    chk("rst_carry", carry, 1'b0);
    chk("rst_zero", zero, 1'b0);
    chk("rst_op_count", op_count, 4'd0);
    chk("rst_in_ready", in_ready, 1'b1);

    // Single transactions from the vector table
    exp_cnt = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      set_req(tbl[i].a, tbl[i].b, tbl[i].sel);
      step();
      in_valid = 1'b0; A = 8'h5A; B = 8'hC3; ALU_Sel = 3'b000;
      step();
      chk($sformatf("vec%0d_valid", i), out_valid, 1'b1);
      chk($sformatf("vec%0d_out", i), ALU_Out, tbl[i].res);
      chk($sformatf("vec%0d_carry", i), carry, tbl[i].c);
      chk($sformatf("vec%0d_zero", i), zero, tbl[i].z);
      step();
      exp_cnt = (exp_cnt + 1) % 16;
      chk($sformatf("vec%0d_count", i), op_count, exp_cnt[3:0]);
      chk($sformatf("vec%0d_idle", i), out_valid, 1'b0);
    end

    // Back-to-back logic ops at full throughput
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i < 6) set_req(8'hCC, 8'hAA, 3'(i + 2));
      else in_valid = 1'b0;
      step();
      if (i >= 1) begin
        chk($sformatf("b2b%0d_valid", i - 1), out_valid, 1'b1);
        chk($sformatf("b2b%0d_out", i - 1), ALU_Out, b2b[i - 1]);
        chk($sformatf("b2b%0d_carry", i - 1), carry, 1'b0);
      end
    end
    step();
    chk("b2b_count", op_count, 4'd6);
    chk("b2b_idle", out_valid, 1'b0);

    // Backpressure: two accepted, third refused, then drain in order
    do_reset();
    out_ready = 1'b0;
    set_req(8'h12, 8'h34, 3'b000);
    #1 chk("bp_rdy0", in_ready, 1'b1);
    step();
    set_req(8'h50, 8'h20, 3'b001);
    #1 chk("bp_rdy1", in_ready, 1'b1);
    step();
    set_req(8'hF0, 8'h0F, 3'b100);
    #1 chk("bp_rdy2_blocked", in_ready, 1'b0);
    chk("bp_valid", out_valid, 1'b1);
    chk("bp_out0", ALU_Out, 8'h46);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("bp_hold%0d_out", i), ALU_Out, 8'h46);
      chk($sformatf("bp_hold%0d_rdy", i), in_ready, 1'b0);
      chk($sformatf("bp_hold%0d_cnt", i), op_count, 4'd0);
    end
    out_ready = 1'b1;
    #1 chk("bp_rdy_release", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk("bp_out1", ALU_Out, 8'h30);
    chk("bp_cnt1", op_count, 4'd1);
    step();
    chk("bp_out2", ALU_Out, 8'hFF);
    chk("bp_valid2", out_valid, 1'b1);
    chk("bp_cnt2", op_count, 4'd2);
    step();
    chk("bp_idle", out_valid, 1'b0);
    chk("bp_cnt3", op_count, 4'd3);

    // Reset with both stages full
    out_ready = 1'b0;
    set_req(8'h01, 8'h01, 3'b000);
    step();
    set_req(8'h02, 8'h02, 3'b000);
    step();
    in_valid = 1'b0;
    chk("mid_full", out_valid, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_valid", out_valid, 1'b0);
    chk("mid_rdy", in_ready, 1'b1);
    chk("mid_cnt", op_count, 4'd0);
    chk("mid_out", ALU_Out, 8'h00);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("mid_stale%0d", i), out_valid, 1'b0);
    end

    // Counter wrap at the 4-bit limit
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      set_req(8'(i), 8'h01, 3'b000);
      step();
      in_valid = 1'b0;
      step();
      step();
      if (i == 14) chk("wrap_max", op_count, 4'd15);
    end
    chk("wrap_zero", op_count, 4'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu8_resp.md
# alu8_resp

Registered, handshaked command responder for the 8-bit ALU. It accepts operation requests (A, B, ALU_Sel) from an initiator over a valid/ready interface and runs them through a two-stage pipeline. It returns ALU_Out with carry/zero flags over a second valid/ready interface. It sits between a command source (sequencer, bus bridge or bench driver) and any result consumer, and adds backpressure, flags and an operation counter to the combinational ALU function.

## Interface
- WIDTH, 8, operand/result width; only 8 is supported.
- CNT_W, 16, width of the completed-operation counter.

- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  responder can accept a request this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- ALU_Sel  input  3  operation select.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result this cycle.
- ALU_Out  output  WIDTH  result.
- carry  output  1  carry (add) or borrow (sub); 0 for logic ops.
- zero  output  1  1 when ALU_Out == 0.
- op_count  output  CNT_W  number of completed output handshakes.

## Operation
- ALU_Sel encoding:
  - 000 A+B
  - 001 A-B
  - 010 A&B
  - 011 A|B
  - 100 A^B
  - 101 ~(A&B)
  - 110 ~(A|B)
  - 111 ~(A^B)
- Arithmetic:
  - Add: 9-bit sum; ALU_Out = sum[7:0], carry = sum[8].
  - Sub: ALU_Out = (A-B) mod 256, carry = 1 when A < B (unsigned borrow).
  - Logic ops: carry = 0.
- Stage 1 (S1): registers A, B, ALU_Sel and s1_valid on an input handshake (in_valid && in_ready).
- Stage 2 (S2): registers the computed result and flags together with out_valid.
- Advance rules:
  - S2 loads from S1 when s1_valid && (!out_valid || out_ready).
  - S2 clears out_valid when out_valid && out_ready and S1 holds nothing to move.
  - S1 loads a new request when in_ready, otherwise keeps its contents.
- in_ready = !s1_valid || !out_valid || out_ready (combinational from out_ready; no combinational path from in_valid).
- While out_valid && !out_ready, ALU_Out/carry/zero hold stable and no data is lost or duplicated.
- op_count increments by 1 on every output handshake and wraps from 2^CNT_W-1 to 0.
- Simultaneous events:
  - Input and output handshakes in the same cycle are both honoured; full throughput is kept.
  - in_valid while S1 and S2 are both full with out_ready=0 is not accepted (in_ready=0); the initiator holds the request.
- A request with in_valid=0 never enters S1, whatever A/B/ALU_Sel are.

## Timing
- Reset (rst=1 at a rising edge) sets:
  - s1_valid=0, out_valid=0.
  - ALU_Out=0x00, carry=0, zero=0.
  - op_count=0.
- After reset, in_ready=1.
- Reset mid-operation discards the contents of S1 and S2 with no output handshake. op_count returns to 0.
- Latency: a request accepted at edge N gives out_valid=1 after edge N+1 (visible in cycle N+1), when S2 is free. Each stalled cycle adds one cycle.
- Throughput: one operation per clock with out_ready held high.
- Capacity: two requests in flight (S1 + S2).

## Test plan
- Reset, then A=0x0F, B=0x01, Sel=000 in one cycle -> next cycle out_valid=1, ALU_Out=0x10, carry=0, zero=0; op_count=1 after the handshake.
- A=0xFF, B=0x01, Sel=000 -> ALU_Out=0x00, carry=1, zero=1. Then A=0x01, B=0x02, Sel=001 -> ALU_Out=0xFF, carry=1.
- Back-to-back logic ops with A=0xCC, B=0xAA and Sel=010..111, out_ready=1 -> ALU_Out sequence 0x88, 0xEE, 0x66, 0x77, 0x11, 0x99 on consecutive cycles, carry=0 throughout, op_count=6.
- Backpressure: out_ready=0 while three requests are offered -> two are accepted and the third sees in_ready=0. ALU_Out holds the first result stable. Releasing out_ready -> all three results arrive in order, none lost or duplicated.
- Reset asserted with S1 and S2 full -> out_valid=0, in_ready=1, op_count=0 on the next cycle, and no stale result appears afterwards.
- Preload op_count near the top by issuing 2^CNT_W operations (or CNT_W=4 in the bench) -> count wraps to 0 exactly on the handshake after the maximum value.
